// File: rtl/decode_stage_p_if.sv
// Port bundle around the ID stage: IF handshake, register-file read ports, WB bypass,
// EX hazard inputs and the registered bundle handed to EX. "master" is the decode stage view.
interface decode_stage_p_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;

    logic [4:0]      rf_rs1_addr;
    logic [4:0]      rf_rs2_addr;
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;

    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            ex_mem_read;
    logic [4:0]      ex_rd;
    logic            flush;

    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic [6:0]      id_opcode;
    logic [4:0]      id_rd;
    logic [4:0]      id_rs1_addr;
    logic [4:0]      id_rs2_addr;
    logic [2:0]      id_funct3;
    logic [6:0]      id_funct7;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_mem_to_reg;
    logic            id_alu_src;
    logic            id_jump;
    logic            id_branch;
    logic            id_illegal;
    logic [1:0]      id_alu_op;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  if_valid, if_instr, if_pc, rf_rs1_data, rf_rs2_data,
               wb_we, wb_rd, wb_data, ex_mem_read, ex_rd, flush, id_ready,
        output if_ready, rf_rs1_addr, rf_rs2_addr, id_valid, id_pc, id_rs1_val,
               id_rs2_val, id_imm, id_opcode, id_rd, id_rs1_addr, id_rs2_addr,
               id_funct3, id_funct7, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_alu_src, id_jump, id_branch, id_illegal,
               id_alu_op, stall_cnt
    );

    modport slave (
        output if_valid, if_instr, if_pc, rf_rs1_data, rf_rs2_data,
               wb_we, wb_rd, wb_data, ex_mem_read, ex_rd, flush, id_ready,
        input  if_ready, rf_rs1_addr, rf_rs2_addr, id_valid, id_pc, id_rs1_val,
               id_rs2_val, id_imm, id_opcode, id_rd, id_rs1_addr, id_rs2_addr,
               id_funct3, id_funct7, id_reg_write, id_mem_read, id_mem_write,
               id_mem_to_reg, id_alu_src, id_jump, id_branch, id_illegal,
               id_alu_op, stall_cnt
    );
endinterface

// File: rtl/decode_stage_p.sv
// RV32I decode stage: one instruction per cycle into a registered EX bundle, latency 1.
// Backpressure: bundle held while id_ready=0; if_ready drops on hold, load-use hazard or flush.
module decode_stage_p #(
    parameter int XLEN          = 32,
    parameter int ENABLE_BYPASS = 1,
    parameter int CNT_W         = 16
) (
    input logic              clk,
    input logic              rst,
    decode_stage_p_if.master bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic       BYPASS_ON = (ENABLE_BYPASS != 0);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            alu_src;
        logic            jump;
        logic            branch;
        logic            illegal;
        logic [1:0]      alu_op;
    } bundle_t;

    logic [31:0]      instr;
    logic [6:0]       opcode;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             is_r, is_i_alu, is_load, is_store, is_branch;
    logic             is_jal, is_jalr, is_lui, is_auipc;
    logic             legal;
    logic             rs1_used, rs2_used;
    logic             hazard, slot_free, accept;
    logic [31:0]      imm32;
    logic [XLEN-1:0]  rs1_val, rs2_val;
    bundle_t          dec;
    bundle_t          bundle_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    assign instr  = bus.if_instr;
    assign opcode = instr[6:0];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign is_r      = (opcode == OP_R);
    assign is_i_alu  = (opcode == OP_I_ALU);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);

    // Every class flag is already zero for an unknown opcode, so illegal words carry no controls.
    assign legal = (instr[1:0] == 2'b11) &&
                   (is_r || is_i_alu || is_load || is_store || is_branch ||
                    is_jal || is_jalr || is_lui || is_auipc);

    assign rs1_used = is_r || is_i_alu || is_load || is_store || is_branch || is_jalr;
    assign rs2_used = is_r || is_store || is_branch;

    assign hazard = bus.if_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((rs1_used && (bus.ex_rd == rs1)) || (rs2_used && (bus.ex_rd == rs2)));

    assign slot_free = !valid_q || bus.id_ready;
    assign accept    = bus.if_valid && bus.if_ready;

    assign bus.if_ready    = slot_free && !hazard && !bus.flush;
    assign bus.rf_rs1_addr = rs1;
    assign bus.rf_rs2_addr = rs2;

    always_comb begin
        imm32 = '0;
        if (is_i_alu || is_load || is_jalr) begin
            imm32 = {{20{instr[31]}}, instr[31:20]};
        end else if (is_store) begin
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        end else if (is_branch) begin
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end else if (is_lui || is_auipc) begin
            imm32 = {instr[31:12], 12'b0};
        end else if (is_jal) begin
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
    end

    always_comb begin
        rs1_val = bus.rf_rs1_data;
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (BYPASS_ON && bus.wb_we && (bus.wb_rd == rs1)) begin
            rs1_val = bus.wb_data;
        end
    end

    always_comb begin
        rs2_val = bus.rf_rs2_data;
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (BYPASS_ON && bus.wb_we && (bus.wb_rd == rs2)) begin
            rs2_val = bus.wb_data;
        end
    end

    always_comb begin
        dec            = '0;
        dec.pc         = bus.if_pc;
        dec.rs1_val    = rs1_val;
        dec.rs2_val    = rs2_val;
        dec.imm        = XLEN'($signed(imm32));
        dec.opcode     = opcode;
        dec.rd         = instr[11:7];
        dec.rs1_addr   = rs1;
        dec.rs2_addr   = rs2;
        dec.funct3     = instr[14:12];
        dec.funct7     = instr[31:25];
        dec.reg_write  = is_r || is_i_alu || is_load || is_jal || is_jalr || is_lui || is_auipc;
        dec.mem_read   = is_load;
        dec.mem_to_reg = is_load;
        dec.mem_write  = is_store;
        dec.alu_src    = legal && !is_r && !is_branch;
        dec.jump       = is_jal || is_jalr;
        dec.branch     = is_branch;
        dec.illegal    = !legal;
        if (is_r || is_i_alu) begin
            dec.alu_op = 2'b10;
        end else if (is_branch) begin
            dec.alu_op = 2'b01;
        end
    end

    // Flush beats accept; a free slot with nothing accepted (including a hazard) becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q  <= 1'b1;
                bundle_q <= dec;
            end else if (slot_free) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.id_valid      = valid_q;
    assign bus.id_pc         = bundle_q.pc;
    assign bus.id_rs1_val    = bundle_q.rs1_val;
    assign bus.id_rs2_val    = bundle_q.rs2_val;
    assign bus.id_imm        = bundle_q.imm;
    assign bus.id_opcode     = bundle_q.opcode;
    assign bus.id_rd         = bundle_q.rd;
    assign bus.id_rs1_addr   = bundle_q.rs1_addr;
    assign bus.id_rs2_addr   = bundle_q.rs2_addr;
    assign bus.id_funct3     = bundle_q.funct3;
    assign bus.id_funct7     = bundle_q.funct7;
    assign bus.id_reg_write  = bundle_q.reg_write;
    assign bus.id_mem_read   = bundle_q.mem_read;
    assign bus.id_mem_write  = bundle_q.mem_write;
    assign bus.id_mem_to_reg = bundle_q.mem_to_reg;
    assign bus.id_alu_src    = bundle_q.alu_src;
    assign bus.id_jump       = bundle_q.jump;
    assign bus.id_branch     = bundle_q.branch;
    assign bus.id_illegal    = bundle_q.illegal;
    assign bus.id_alu_op     = bundle_q.alu_op;
    assign bus.stall_cnt     = cnt_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: directed scenarios then random traffic, both checked against a
// transaction-level reference of the decode rules and the accept/hold/bubble/flush behaviour.
module tb_decode_stage_p;
    localparam int XLEN    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_p_if #(.XLEN(XLEN), .CNT_W(CNT_W)) a ();
    decode_stage_p_if #(.XLEN(XLEN), .CNT_W(CNT_W)) b ();

    decode_stage_p #(.XLEN(XLEN), .ENABLE_BYPASS(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(a.master));
    decode_stage_p #(.XLEN(XLEN), .ENABLE_BYPASS(0), .CNT_W(CNT_W)) dut_nobyp (
        .clk(clk), .rst(rst), .bus(b.master));

    logic [31:0] regs [32];

    assign a.rf_rs1_data = regs[a.rf_rs1_addr];
    assign a.rf_rs2_data = regs[a.rf_rs2_addr];
    assign b.rf_rs1_data = regs[b.rf_rs1_addr];
    assign b.rf_rs2_data = regs[b.rf_rs2_addr];
    assign b.if_valid    = a.if_valid;
    assign b.if_instr    = a.if_instr;
    assign b.if_pc       = a.if_pc;
    assign b.wb_we       = a.wb_we;
    assign b.wb_rd       = a.wb_rd;
    assign b.wb_data     = a.wb_data;
    assign b.ex_mem_read = a.ex_mem_read;
    assign b.ex_rd       = a.ex_rd;
    assign b.flush       = a.flush;
    assign b.id_ready    = a.id_ready;

    typedef struct packed {
        logic [31:0] pc, rs1v, rs2v, imm;
        logic [6:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        rw, mr, mw, m2r, asrc, jmp, br, ill;
        logic [1:0]  aop;
    } bun_t;

    int   n_chk = 0;
    int   n_err = 0;
    logic m_valid = 1'b0;
    int   m_cnt = 0;
    bun_t m_b = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] opval(input logic [4:0] ad, input logic [31:0] rfv);
        if (ad == 5'd0) return 32'd0;
        if (a.wb_we && a.wb_rd == ad) return a.wb_data;
        return rfv;
    endfunction

    function automatic bun_t ref_decode();
        bun_t        r;
        logic [31:0] ins;
        logic [6:0]  op;
        logic        r_t, i_t, ld, st, br, jal, jalr, lui, aui;
        logic [11:0] f12;
        logic [12:0] f13;
        logic [20:0] f21;
        ins  = a.if_instr;
        op   = ins[6:0];
        r_t  = (op == 7'h33);
        i_t  = (op == 7'h13);
        ld   = (op == 7'h03);
        st   = (op == 7'h23);
        br   = (op == 7'h63);
        jal  = (op == 7'h6F);
        jalr = (op == 7'h67);
        lui  = (op == 7'h37);
        aui  = (op == 7'h17);
        r      = '0;
        r.pc   = a.if_pc;
        r.opc  = op;
        r.rd   = ins[11:7];
        r.rs1  = ins[19:15];
        r.rs2  = ins[24:20];
        r.f3   = ins[14:12];
        r.f7   = ins[31:25];
        r.rs1v = opval(r.rs1, regs[r.rs1]);
        r.rs2v = opval(r.rs2, regs[r.rs2]);
        r.ill  = !(r_t || i_t || ld || st || br || jal || jalr || lui || aui);
        r.rw   = r_t || i_t || ld || jal || jalr || lui || aui;
        r.mr   = ld;
        r.m2r  = ld;
        r.mw   = st;
        r.asrc = !r.ill && !r_t && !br;
        r.jmp  = jal || jalr;
        r.br   = br;
        r.aop  = (r_t || i_t) ? 2'b10 : (br ? 2'b01 : 2'b00);
        if (i_t || ld || jalr) begin
            f12 = ins[31:20];
            r.imm = int'($signed(f12));
        end else if (st) begin
            f12 = {ins[31:25], ins[11:7]};
            r.imm = int'($signed(f12));
        end else if (br) begin
            f13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            r.imm = int'($signed(f13));
        end else if (lui || aui) begin
            r.imm = 32'(ins[31:12]) << 12;
        end else if (jal) begin
            f21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            r.imm = int'($signed(f21));
        end
        return r;
    endfunction

    function automatic logic ref_hazard();
        logic [6:0] op;
        logic       u1, u2;
        op = a.if_instr[6:0];
        u1 = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23) ||
             (op == 7'h63) || (op == 7'h67);
        u2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
        return a.if_valid && a.ex_mem_read && (a.ex_rd != 5'd0) &&
               ((u1 && a.ex_rd == a.if_instr[19:15]) || (u2 && a.ex_rd == a.if_instr[24:20]));
    endfunction

    task automatic check_bundle();
        check("id_pc", a.id_pc, m_b.pc);
        check("id_rs1_val", a.id_rs1_val, m_b.rs1v);
        check("id_rs2_val", a.id_rs2_val, m_b.rs2v);
        check("id_imm", a.id_imm, m_b.imm);
        check("id_opcode", 32'(a.id_opcode), 32'(m_b.opc));
        check("id_rd", 32'(a.id_rd), 32'(m_b.rd));
        check("id_rs1_addr", 32'(a.id_rs1_addr), 32'(m_b.rs1));
        check("id_rs2_addr", 32'(a.id_rs2_addr), 32'(m_b.rs2));
        check("id_funct3", 32'(a.id_funct3), 32'(m_b.f3));
        check("id_funct7", 32'(a.id_funct7), 32'(m_b.f7));
        check("id_ctrl", 32'({a.id_reg_write, a.id_mem_read, a.id_mem_write, a.id_mem_to_reg,
                              a.id_alu_src, a.id_jump, a.id_branch, a.id_illegal, a.id_alu_op}),
              32'({m_b.rw, m_b.mr, m_b.mw, m_b.m2r, m_b.asrc, m_b.jmp, m_b.br, m_b.ill, m_b.aop}));
    endtask

    // Entered just after a falling edge with inputs already set; returns on the next falling edge.
    task automatic cycle();
        logic hz, rdy;
        bun_t nxt;
        #1;
        hz  = ref_hazard();
        rdy = (!m_valid || a.id_ready) && !hz && !a.flush;
        check("if_ready", 32'(a.if_ready), 32'(rdy));
        check("rf_rs1_addr", 32'(a.rf_rs1_addr), 32'(a.if_instr[19:15]));
        check("rf_rs2_addr", 32'(a.rf_rs2_addr), 32'(a.if_instr[24:20]));
        nxt = ref_decode();
        @(posedge clk);
        if (hz && m_cnt < CNT_MAX) m_cnt++;
        if (a.flush) m_valid = 1'b0;
        else if (a.if_valid && rdy) begin
            m_valid = 1'b1;
            m_b     = nxt;
        end else if (!m_valid || a.id_ready) m_valid = 1'b0;
        #1;
        check("id_valid", 32'(a.id_valid), 32'(m_valid));
        check("stall_cnt", 32'(a.stall_cnt), m_cnt);
        if (m_valid) check_bundle();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: w[6:0] = 7'h33;
            1: w[6:0] = 7'h13;
            2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h6F;
            6: w[6:0] = 7'h67;
            7: w[6:0] = 7'h37;
            8: w[6:0] = 7'h17;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) begin
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
        end
        return w;
    endfunction

    logic [31:0] held_imm, held_pc;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[7]       = 32'd0;
        rst           = 1'b1;
        a.if_valid    = 1'b0;
        a.if_instr    = 32'h0000_0013;
        a.if_pc       = 32'd0;
        a.wb_we       = 1'b0;
        a.wb_rd       = 5'd0;
        a.wb_data     = 32'd0;
        a.ex_mem_read = 1'b0;
        a.ex_rd       = 5'd0;
        a.flush       = 1'b0;
        a.id_ready    = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_id_valid", 32'(a.id_valid), 32'd0);
        check("rst_stall_cnt", 32'(a.stall_cnt), 32'd0);
        check("rst_id_imm", a.id_imm, 32'd0);
        check("rst_id_pc", a.id_pc, 32'd0);
        check("rst_id_reg_write", 32'(a.id_reg_write), 32'd0);
        check("rst_if_ready", 32'(a.if_ready), 32'd1);
        rst = 1'b0;

        // ADDI x5,x0,-1
        a.if_valid = 1'b1;
        a.if_instr = 32'hFFF0_0293;
        a.if_pc    = 32'h100;
        cycle();
        check("addi_valid", 32'(a.id_valid), 32'd1);
        check("addi_imm", a.id_imm, 32'hFFFF_FFFF);
        check("addi_rd", 32'(a.id_rd), 32'd5);
        check("addi_reg_write", 32'(a.id_reg_write), 32'd1);
        check("addi_alu_src", 32'(a.id_alu_src), 32'd1);
        check("addi_alu_op", 32'(a.id_alu_op), 32'd2);

        // Load-use: LW in EX writing x3, ADD x4,x3,x2 on IF
        a.ex_mem_read = 1'b1;
        a.ex_rd       = 5'd3;
        a.if_instr    = 32'h0021_8233;
        a.if_pc       = 32'h104;
        #1 check("haz_if_ready", 32'(a.if_ready), 32'd0);
        cycle();
        check("haz_bubble", 32'(a.id_valid), 32'd0);
        check("haz_stall_cnt", 32'(a.stall_cnt), 32'd1);
        a.ex_mem_read = 1'b0;
        cycle();
        check("haz_accept_valid", 32'(a.id_valid), 32'd1);
        check("haz_accept_rd", 32'(a.id_rd), 32'd4);

        // SW x7,8(x1) with WB writing x7 in the same cycle
        a.wb_we    = 1'b1;
        a.wb_rd    = 5'd7;
        a.wb_data  = 32'hDEAD_BEEF;
        a.if_instr = 32'h0070_A423;
        a.if_pc    = 32'h108;
        cycle();
        check("byp_rs2_val", a.id_rs2_val, 32'hDEAD_BEEF);
        check("byp_imm", a.id_imm, 32'd8);
        check("byp_mem_write", 32'(a.id_mem_write), 32'd1);
        check("nobyp_rs2_val", b.id_rs2_val, 32'd0);
        a.wb_we = 1'b0;

        // BEQ accepted then held for 3 cycles; B-imm bit 11 comes from instr[7]=1
        a.if_instr = 32'hFE00_0EE3;
        a.if_pc    = 32'h10C;
        cycle();
        check("beq_imm", a.id_imm, 32'hFFFF_FFFC);
        check("beq_branch", 32'(a.id_branch), 32'd1);
        held_imm   = a.id_imm;
        held_pc    = a.id_pc;
        a.id_ready = 1'b0;
        a.if_instr = 32'h0010_0093;
        a.if_pc    = 32'h110;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_if_ready", 32'(a.if_ready), 32'd0);
            check("hold_imm", a.id_imm, held_imm);
            check("hold_pc", a.id_pc, held_pc);
        end

        // Flush while holding and while IF presents an instruction
        a.flush = 1'b1;
        #1 check("flush_if_ready", 32'(a.if_ready), 32'd0);
        cycle();
        check("flush_valid", 32'(a.id_valid), 32'd0);
        a.flush    = 1'b0;
        a.id_ready = 1'b1;
        a.if_valid = 1'b0;
        cycle();
        check("flush_not_accepted", 32'(a.id_valid), 32'd0);

        // Illegal opcode 0x7F
        a.if_valid = 1'b1;
        a.if_instr = 32'h0000_007F;
        cycle();
        check("ill_valid", 32'(a.id_valid), 32'd1);
        check("ill_flag", 32'(a.id_illegal), 32'd1);
        check("ill_ctrl", 32'({a.id_reg_write, a.id_mem_read, a.id_mem_write, a.id_mem_to_reg,
                               a.id_alu_src, a.id_jump, a.id_branch, a.id_alu_op}), 32'd0);

        // Saturate the stall counter
        a.ex_mem_read = 1'b1;
        a.ex_rd       = 5'd3;
        a.if_instr    = 32'h0021_8233;
        repeat (20) cycle();
        check("sat_stall_cnt", 32'(a.stall_cnt), 32'd15);
        a.ex_mem_read = 1'b0;

        // Reset in the middle of a held transfer
        a.id_ready = 1'b0;
        a.if_instr = 32'hFFF0_0293;
        cycle();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(a.id_valid), 32'd0);
        check("mid_rst_stall_cnt", 32'(a.stall_cnt), 32'd0);
        check("mid_rst_pc", a.id_pc, 32'd0);
        m_valid = 1'b0;
        m_cnt   = 0;
        m_b     = '0;
        @(negedge clk);
        rst        = 1'b0;
        a.id_ready = 1'b1;

        for (int n = 0; n < 800; n++) begin
            a.if_valid    = ($urandom_range(0, 9) < 8);
            a.if_instr    = rand_instr();
            a.if_pc       = $urandom;
            a.id_ready    = ($urandom_range(0, 9) < 7);
            a.flush       = ($urandom_range(0, 19) == 0);
            a.ex_mem_read = ($urandom_range(0, 2) == 0);
            a.ex_rd       = 5'($urandom_range(0, 7));
            a.wb_we       = ($urandom_range(0, 1) == 1);
            a.wb_rd       = 5'($urandom_range(0, 7));
            a.wb_data     = $urandom;
            regs[$urandom_range(0, 31)] = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
